// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - width helpers, entry layout and parameter checks for the AXI-Stream FIFO
`ifndef AXIS_PKG_SV
`define AXIS_PKG_SV

// One stored word: tlast sits above tdata so a single array holds both.
`define AXIS_ENTRY_T(W) struct packed { logic tlast; logic [(W)-1:0] tdata; }

package axis_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

`endif

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - entry array with synchronous write and asynchronous read
module axis_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read gives first-word fall-through without an output stage.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO with optional store-and-forward on tlast
module axis_fifo
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH        = 32,
  parameter int DEPTH              = 16,
  parameter int PACKET_MODE        = 0,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [TDATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [TDATA_WIDTH-1:0]      m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]  fill_level,
  output logic                        almost_full
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_THRESH);

  typedef `AXIS_ENTRY_T(TDATA_WIDTH) entry_t;

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $fatal(1, "axis_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_ok(ALMOST_FULL_THRESH, DEPTH)) begin : g_thresh_check
    $fatal(1, "axis_fifo: ALMOST_FULL_THRESH must lie in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          flush_q, flush_d;
  logic          s_ready_q, s_ready_d;
  logic          afull_q, afull_d;

  entry_t wr_entry;
  entry_t rd_entry;
  logic   m_valid;
  logic   push;
  logic   pop;
  logic   push_last;
  logic   pop_last;

  assign wr_entry.tlast = s_axis_tlast;
  assign wr_entry.tdata = s_axis_tdata;

  axis_fifo_ram #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // In packet mode the output opens only once a whole packet is held, or when flushing.
  assign m_valid = (count_q != '0) &&
                   ((PACKET_MODE == 0) || (pkt_cnt_q != '0) || flush_q);

  assign push      = s_axis_tvalid & s_ready_q;
  assign pop       = m_valid & m_axis_tready;
  assign push_last = push & s_axis_tlast;
  assign pop_last  = pop & rd_entry.tlast;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    pkt_cnt_d = pkt_cnt_q;
    unique case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // A full FIFO with no complete packet would never drain; stream it through instead.
    flush_d = flush_q;
    if (pop_last) begin
      flush_d = 1'b0;
    end else if ((PACKET_MODE != 0) && (count_q == FULL_CNT) && (pkt_cnt_q == '0)) begin
      flush_d = 1'b1;
    end

    s_ready_d = (count_d != FULL_CNT);
    afull_d   = (count_d >= AF_CNT);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      flush_q   <= 1'b0;
      s_ready_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      flush_q   <= flush_d;
      s_ready_q <= s_ready_d;
      afull_q   <= afull_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = rd_entry.tdata;
  assign m_axis_tlast  = rd_entry.tlast;
  assign fill_level    = count_q;
  assign almost_full   = afull_q;

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - randomized, model-checked bench for axis_fifo in both modes
module tb_axis_fifo;

  localparam int W   = 32;
  localparam int D   = 16;
  localparam int CW  = 5;
  localparam int AFT = D - 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [W-1:0]  ct_s_tdata = '0, pk_s_tdata = '0;
  logic          ct_s_tlast = 1'b0, pk_s_tlast = 1'b0;
  logic          ct_s_tvalid = 1'b0, pk_s_tvalid = 1'b0;
  logic          ct_s_tready, pk_s_tready;
  logic [W-1:0]  ct_m_tdata, pk_m_tdata;
  logic          ct_m_tlast, pk_m_tlast;
  logic          ct_m_tvalid, pk_m_tvalid;
  logic          ct_m_tready = 1'b0, pk_m_tready = 1'b0;
  logic [CW-1:0] ct_fill, pk_fill;
  logic          ct_af, pk_af;

  axis_fifo #(.TDATA_WIDTH(W), .DEPTH(D), .PACKET_MODE(0), .ALMOST_FULL_THRESH(AFT)) u_ct (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(ct_s_tdata), .s_axis_tlast(ct_s_tlast), .s_axis_tvalid(ct_s_tvalid),
    .s_axis_tready(ct_s_tready),
    .m_axis_tdata(ct_m_tdata), .m_axis_tlast(ct_m_tlast), .m_axis_tvalid(ct_m_tvalid),
    .m_axis_tready(ct_m_tready),
    .fill_level(ct_fill), .almost_full(ct_af)
  );

  axis_fifo #(.TDATA_WIDTH(W), .DEPTH(D), .PACKET_MODE(1), .ALMOST_FULL_THRESH(AFT)) u_pk (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(pk_s_tdata), .s_axis_tlast(pk_s_tlast), .s_axis_tvalid(pk_s_tvalid),
    .s_axis_tready(pk_s_tready),
    .m_axis_tdata(pk_m_tdata), .m_axis_tlast(pk_m_tlast), .m_axis_tvalid(pk_m_tvalid),
    .m_axis_tready(pk_m_tready),
    .fill_level(pk_fill), .almost_full(pk_af)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents: {tlast, tdata} in arrival order, plus the packet-mode flush state.
  logic [W:0] q_ct[$];
  logic [W:0] q_pk[$];
  bit         flush_pk = 1'b0;

  function automatic bit has_last();
    foreach (q_pk[i]) if (q_pk[i][W]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle on the selected FIFO: drive, compare against the model, then advance it.
  task automatic cyc(input bit pm, input bit v, input logic [W-1:0] d, input bit l,
                     input bit r, output bit acc);
    int sz;
    bit ev, er, hl, push, pop;
    logic [W:0] fr, popped;
    logic ov, ol, ordy, oaf;
    logic [W-1:0] od;
    logic [CW-1:0] ofl;
    @(negedge aclk);
    ct_s_tvalid = pm ? 1'b0 : v;  ct_s_tdata = d; ct_s_tlast = l; ct_m_tready = pm ? 1'b0 : r;
    pk_s_tvalid = pm ? v : 1'b0;  pk_s_tdata = d; pk_s_tlast = l; pk_m_tready = pm ? r : 1'b0;
    sz = pm ? q_pk.size() : q_ct.size();
    hl = pm ? has_last() : 1'b0;
    fr = '0;
    if (sz != 0) fr = pm ? q_pk[0] : q_ct[0];
    ev = (sz != 0) && (!pm || hl || flush_pk);
    er = (sz != D);
    ov = pm ? pk_m_tvalid : ct_m_tvalid;
    ol = pm ? pk_m_tlast : ct_m_tlast;
    od = pm ? pk_m_tdata : ct_m_tdata;
    ordy = pm ? pk_s_tready : ct_s_tready;
    ofl = pm ? pk_fill : ct_fill;
    oaf = pm ? pk_af : ct_af;
    checks++;
    if (ov !== ev) begin
      errors++; $display("FAIL m_tvalid pm=%0d t=%0t: got %b expected %b", pm, $time, ov, ev);
    end
    if (ev) begin
      checks++;
      if ({ol, od} !== fr) begin
        errors++; $display("FAIL m_data pm=%0d t=%0t: got %h expected %h", pm, $time, {ol, od}, fr);
      end
    end
    checks++;
    if (ordy !== er) begin
      errors++; $display("FAIL s_tready pm=%0d t=%0t: got %b expected %b", pm, $time, ordy, er);
    end
    checks++;
    if (ofl !== CW'(sz)) begin
      errors++; $display("FAIL fill_level pm=%0d t=%0t: got %0d expected %0d", pm, $time, ofl, sz);
    end
    checks++;
    if (oaf !== (sz >= AFT)) begin
      errors++; $display("FAIL almost_full pm=%0d t=%0t: got %b expected %b", pm, $time, oaf, sz >= AFT);
    end
    push = v && er;
    pop  = ev && r;
    acc  = push;
    @(posedge aclk);
    if (pm) begin
      if (pop && fr[W]) flush_pk = 1'b0;
      else if (sz == D && !hl) flush_pk = 1'b1;
      if (pop) popped = q_pk.pop_front();
      if (push) q_pk.push_back({l, d});
    end else begin
      if (pop) popped = q_ct.pop_front();
      if (push) q_ct.push_back({l, d});
    end
  endtask

  task automatic drain(input bit pm);
    bit acc;
    int n = 0;
    while ((pm ? q_pk.size() : q_ct.size()) != 0 && n < 200) begin
      if (pm && !has_last() && !flush_pk) cyc(pm, 1'b1, W'($urandom), 1'b1, 1'b1, acc);
      else cyc(pm, 1'b0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    #1;
    checks++;
    if (n >= 200 || (pm ? pk_fill : ct_fill) !== '0) begin
      errors++; $display("FAIL drain pm=%0d: cycles %0d fill %0d expected empty", pm, n, pm ? pk_fill : ct_fill);
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    ct_s_tvalid = 1'b0; pk_s_tvalid = 1'b0; ct_m_tready = 1'b0; pk_m_tready = 1'b0;
    #1;
    checks++;
    if ({ct_s_tready, ct_m_tvalid, ct_af, ct_fill} !== '0) begin
      errors++; $display("FAIL reset_ct: tready=%b tvalid=%b af=%b fill=%0d expected all zero",
                         ct_s_tready, ct_m_tvalid, ct_af, ct_fill);
    end
    checks++;
    if ({pk_s_tready, pk_m_tvalid, pk_af, pk_fill} !== '0) begin
      errors++; $display("FAIL reset_pk: tready=%b tvalid=%b af=%b fill=%0d expected all zero",
                         pk_s_tready, pk_m_tvalid, pk_af, pk_fill);
    end
    q_ct.delete(); q_pk.delete(); flush_pk = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
  endtask

  task automatic test_fall_through();
    bit acc;
    int peak = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b1, W'(i), 1'b0, 1'b1, acc);
      #1 if (int'(ct_fill) > peak) peak = int'(ct_fill);
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    #1;
    checks++;
    if (peak != 1) begin
      errors++; $display("FAIL ft_peak_fill: got %0d expected 1", peak);
    end
    drain(1'b0);
  endtask

  task automatic test_full();
    bit acc;
    for (int i = 1; i <= 20; i++) cyc(1'b0, 1'b1, W'(i), 1'b0, 1'b0, acc);
    #1;
    checks++;
    if ({ct_fill, ct_af, ct_s_tready} !== {CW'(D), 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_state: fill=%0d af=%b tready=%b expected 16 1 0", ct_fill, ct_af, ct_s_tready);
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    #1;
    checks++;
    if ({ct_s_tready, ct_m_tdata} !== {1'b1, W'(2)}) begin
      errors++; $display("FAIL full_pop_one: tready=%b head=%h expected 1 00000002", ct_s_tready, ct_m_tdata);
    end
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    bit acc;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, acc);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, W'($urandom), 1'b0, 1'b1, acc);
    #1;
    checks++;
    if (ct_fill !== CW'(8)) begin
      errors++; $display("FAIL b2b_fill: got %0d expected 8", ct_fill);
    end
    drain(1'b0);
  endtask

  task automatic test_packet();
    bit acc;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, W'(32'hA0 + i), i == 4, 1'b1, acc);
    drain(1'b1);
  endtask

  task automatic test_oversize();
    bit acc;
    int i = 1, n = 0;
    while (i <= 20 && n < 100) begin
      cyc(1'b1, 1'b1, W'(32'hB00 + i), i == 20, 1'b1, acc);
      if (acc) i++;
      n++;
    end
    checks++;
    if (i <= 20) begin
      errors++; $display("FAIL oversize_accept: accepted %0d words expected 20", i - 1);
    end
    drain(1'b1);
    // With flush cleared, a lone word without tlast must be held back.
    for (int k = 0; k < 3; k++) cyc(1'b1, k == 0, W'(32'hC0), 1'b0, 1'b1, acc);
    #1;
    checks++;
    if (pk_m_tvalid !== 1'b0) begin
      errors++; $display("FAIL oversize_flush_clear: tvalid=%b expected 0", pk_m_tvalid);
    end
    drain(1'b1);
  endtask

  task automatic test_mid_reset();
    bit acc;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, W'(32'hD0 + i), 1'b0, 1'b0, acc);
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({ct_m_tvalid, ct_fill, ct_s_tready} !== '0) begin
      errors++; $display("FAIL mid_reset: tvalid=%b fill=%0d tready=%b expected 0 0 0",
                         ct_m_tvalid, ct_fill, ct_s_tready);
    end
    q_ct.delete(); q_pk.delete(); flush_pk = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, W'(32'hE0 + i), 1'b0, 1'b1, acc);
    drain(1'b0);
  endtask

  task automatic test_random(input bit pm);
    bit acc;
    for (int i = 0; i < 400; i++) begin
      cyc(pm, ($urandom % 4) != 0, W'($urandom), ($urandom % 6) == 0, ($urandom % 3) != 0, acc);
    end
    drain(pm);
  endtask

  initial begin
    test_reset();
    test_fall_through();
    test_full();
    test_back_to_back();
    test_packet();
    test_oversize();
    test_mid_reset();
    test_random(1'b0);
    test_random(1'b1);
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
